// File: rtl/sha3_absorb_ctrl.sv
// SHA3 absorb sequencer: packs AXI-Stream beats into rate-sized blocks, applies
// multi-rate padding and hands each block to the Keccak core one at a time.
module sha3_absorb_ctrl #(
   parameter int          DATA_WIDTH = 64,
   parameter int          RATE_BITS  = 1088,
   parameter logic [7:0]  DOMAIN_PAD = 8'h06
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [DATA_WIDTH-1:0]   s_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_tkeep,
   input  logic                    s_tvalid,
   input  logic                    s_tlast,
   output logic                    s_tready,
   output logic [RATE_BITS-1:0]    blk_data,
   output logic                    blk_valid,
   input  logic                    blk_ready,
   output logic                    blk_first,
   output logic                    blk_last,
   input  logic                    perm_done,
   output logic                    busy,
   output logic [15:0]             blk_count
);

   localparam int W      = RATE_BITS / DATA_WIDTH;
   localparam int BPB    = DATA_WIDTH / 8;
   localparam int RB     = RATE_BITS / 8;
   localparam int WIDX_W = (W > 1) ? $clog2(W) : 1;
   localparam int PW     = $clog2(RB + 1);

   typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT_PERM} state_t;

   state_t                 state;
   logic [WIDX_W-1:0]      widx;
   logic [RATE_BITS-1:0]   buffer;
   logic                   first_flag;
   logic                   pad_pending;
   logic [PW-1:0]          pad_pos;

   int                     keep_k;
   logic [DATA_WIDTH-1:0]  beat_word;
   logic [PW-1:0]          last_pos;
   logic                   accept;

   // Length of the run of ones in tkeep starting at byte 0; later bits are ignored.
   function automatic int keep_len(input logic [BPB-1:0] keep);
      int n;
      n = 0;
      for (int i = 0; i < BPB; i++)
         if (keep[i] && (n == i)) n++;
      return n;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mask_beat(input logic [DATA_WIDTH-1:0] d,
                                                       input int k);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int b = 0; b < BPB; b++)
         if (b < k) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [RATE_BITS-1:0] pad_block(input logic [RATE_BITS-1:0] b,
                                                      input logic [PW-1:0] pos);
      logic [RATE_BITS-1:0] r;
      r = b;
      r[8*int'(pos) +: 8] = r[8*int'(pos) +: 8] | DOMAIN_PAD;
      r[RATE_BITS-1 -: 8] = r[RATE_BITS-1 -: 8] | 8'h80;
      return r;
   endfunction

   assign keep_k    = keep_len(s_tkeep);
   assign beat_word = s_tlast ? mask_beat(s_tdata, keep_k) : s_tdata;
   assign last_pos  = PW'(int'(widx) * BPB + keep_k);
   assign accept    = s_tvalid && s_tready;
   assign blk_data  = buffer;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state       <= IDLE;
         widx        <= '0;
         buffer      <= '0;
         first_flag  <= 1'b0;
         pad_pending <= 1'b0;
         pad_pos     <= '0;
         s_tready    <= 1'b0;
         blk_valid   <= 1'b0;
         blk_first   <= 1'b0;
         blk_last    <= 1'b0;
         busy        <= 1'b0;
         blk_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               first_flag  <= 1'b1;
               buffer      <= '0;
               blk_count   <= '0;
               widx        <= '0;
               pad_pending <= 1'b0;
               blk_last    <= 1'b0;
               busy        <= 1'b1;
               s_tready    <= 1'b1;
               state       <= FILL;
            end
            FILL: begin
               if (accept) begin
                  buffer[DATA_WIDTH*int'(widx) +: DATA_WIDTH] <= beat_word;
                  if (s_tlast) begin
                     s_tready <= 1'b0;
                     // A full final block has no room for padding: issue it as data
                     // and pad a fresh block after the permutation.
                     if (last_pos == PW'(RB)) begin
                        pad_pending <= 1'b1;
                        blk_last    <= 1'b0;
                        blk_first   <= first_flag;
                        blk_valid   <= 1'b1;
                        state       <= ISSUE;
                     end else begin
                        pad_pos <= last_pos;
                        state   <= PAD;
                     end
                  end else if (widx == WIDX_W'(W - 1)) begin
                     s_tready  <= 1'b0;
                     blk_last  <= 1'b0;
                     blk_first <= first_flag;
                     blk_valid <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     widx <= widx + WIDX_W'(1);
                  end
               end
            end
            PAD: begin
               buffer    <= pad_block(buffer, pad_pos);
               blk_last  <= 1'b1;
               blk_first <= first_flag;
               blk_valid <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: begin
               if (blk_ready) begin
                  blk_valid  <= 1'b0;
                  first_flag <= 1'b0;
                  if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
                  state      <= WAIT_PERM;
               end
            end
            WAIT_PERM: begin
               if (perm_done) begin
                  buffer <= '0;
                  widx   <= '0;
                  if (pad_pending) begin
                     pad_pending <= 1'b0;
                     pad_pos     <= '0;
                     state       <= PAD;
                  end else if (blk_last) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     s_tready <= 1'b1;
                     state    <= FILL;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
